// File: rtl/elastic_pipe_if.sv
// Valid/ready stream bundle used on both sides of elastic_pipe.
// master drives valid/data, slave drives ready.
interface elastic_pipe_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_pipe.sv
// DEPTH-slice bubble-collapsing valid/ready register pipeline with flush and occupancy count.
// Define ELASTIC_PIPE_SKID_EN to add an output skid register that cuts out_ready -> in_ready.
module elastic_pipe #(
  parameter  int   DATA_WIDTH = 16,
  parameter  int   DEPTH      = 3,
  parameter  logic RST_VALUE  = 1'b0,
  localparam int   OCC_W      = $clog2(DEPTH+2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  elastic_pipe_if.slave        in_if,
  elastic_pipe_if.master       out_if,
  output logic [OCC_W-1:0]     occupancy
);

  localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{RST_VALUE}};
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int MAX_OCC = DEPTH + 1;
`else
  localparam int MAX_OCC = DEPTH;
`endif

  if (DEPTH < 1) begin : g_cfg_err
    $error("elastic_pipe: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]                 v_q, v_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0]                 src_v;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] src_d;
  logic [DEPTH-1:0]                 rdy;
  logic                             tail_rdy;
  logic                             in_xfer, out_xfer;
  logic [OCC_W-1:0]                 occ_q, occ_d;

  // Slice k is free when it or any slice downstream of it holds a bubble,
  // or the stage after the last slice takes its item this cycle.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    assign rdy[k] = tail_rdy | ~(&v_q[DEPTH-1:k]);
    if (k == 0) begin : g_head
      assign src_v[k] = in_if.valid;
      assign src_d[k] = in_if.data;
    end else begin : g_chain
      assign src_v[k] = v_q[k-1];
      assign src_d[k] = d_q[k-1];
    end
  end

  assign in_if.ready = rdy[0] & ~clr;
  assign in_xfer     = in_if.valid & in_if.ready;
  assign out_xfer    = out_if.valid & out_if.ready;
  assign occupancy   = occ_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr) begin
      v_d = '0;
      d_d = {DEPTH{FILL}};
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = src_v[k];
          // Data only moves with a valid item, so an emptied slice keeps its last payload.
          if (src_v[k]) d_d[k] = src_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= {DEPTH{FILL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`ifdef ELASTIC_PIPE_SKID_EN
  logic                  sv_q, sv_d;
  logic [DATA_WIDTH-1:0] sd_q, sd_d;

  // The last slice only waits on registered skid state, never on out_ready.
  assign tail_rdy     = ~sv_q;
  assign out_if.valid = sv_q | v_q[DEPTH-1];
  assign out_if.data  = sv_q ? sd_q : d_q[DEPTH-1];

  always_comb begin
    sv_d = sv_q;
    sd_d = sd_q;
    if (clr) begin
      sv_d = 1'b0;
      sd_d = FILL;
    end else if (sv_q) begin
      if (out_if.ready) sv_d = 1'b0;
    end else if (v_q[DEPTH-1] && !out_if.ready) begin
      sv_d = 1'b1;
      sd_d = d_q[DEPTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= 1'b0;
      sd_q <= FILL;
    end else begin
      sv_q <= sv_d;
      sd_q <= sd_d;
    end
  end
`else
  assign tail_rdy     = out_if.ready;
  assign out_if.valid = v_q[DEPTH-1];
  assign out_if.data  = d_q[DEPTH-1];
`endif

  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else begin
      unique case ({in_xfer, out_xfer})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) 32'(occ_q) <= MAX_OCC);
  a_clr_blocks_input: assert property (@(posedge clk) disable iff (!rst_n) clr |-> !in_if.ready);

endmodule

// File: tb/tb_elastic_pipe.sv
// Randomised scoreboard bench for elastic_pipe (DATA_WIDTH=16, DEPTH=3, RST_VALUE=0).
// The reference is a plain FIFO queue: order, occupancy and flush are checked against it.
module tb_elastic_pipe;
  localparam int DW    = 16;
  localparam int DEPTH = 3;
  localparam int OW    = $clog2(DEPTH+2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int MAXOCC = DEPTH + 1;
`else
  localparam int MAXOCC = DEPTH;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic [OW-1:0] occupancy;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mq[$];

  elastic_pipe_if #(.DATA_WIDTH(DW)) up_if();
  elastic_pipe_if #(.DATA_WIDTH(DW)) dn_if();

  elastic_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RST_VALUE(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_if     (up_if),
    .out_if    (dn_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: inputs already driven after the falling edge; check output, clock, update model.
  task automatic tick(output bit ix, output bit ox);
    #1;
    ix = up_if.valid && up_if.ready;
    ox = dn_if.valid && dn_if.ready;
    if (ox) begin
      if (mq.size() == 0) chk("out_unexpected", 32'(dn_if.valid), 32'd0);
      else                chk("out_data", 32'(dn_if.data), 32'(mq[0]));
    end
    @(posedge clk);
    if (clr) mq.delete();
    else begin
      if (ox && mq.size() > 0) void'(mq.pop_front());
      if (ix) mq.push_back(up_if.data);
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ix, ox;
    int   acc, outs, fa, fo, lo;
    logic r1, r2;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // reset state, clock not yet toggled
    #2;
    chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
    chk("rst_out_data",  32'(dn_if.data),  32'd0);
    chk("rst_occ",       32'(occupancy),   32'd0);
    chk("rst_in_ready",  32'(up_if.ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // unstalled stream of 1..8
    dn_if.ready = 1'b1;
    acc = 0; outs = 0; fa = -1; fo = -1; lo = -1;
    for (int c = 0; c < 40 && outs < 8; c++) begin
      up_if.valid = (acc < 8);
      up_if.data  = DW'(acc + 1);
      tick(ix, ox);
      if (ix) begin if (fa < 0) fa = c; acc++; end
      if (ox) begin if (fo < 0) fo = c; lo = c; outs++; end
      if (c >= 2 && c <= 7) chk("stream_occ", 32'(occupancy), 32'd3);
    end
    up_if.valid = 1'b0;
    chk("stream_latency", 32'(fo - fa), 32'd3);
    chk("stream_rate",    32'(lo - fo), 32'd7);
    chk("stream_count",   32'(outs),    32'd8);

    // fill against a stalled sink, then drain in order
    dn_if.ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      up_if.valid = 1'b1;
      up_if.data  = DW'(acc + 1);
      #1;
      if (!up_if.ready) break;
      tick(ix, ox);
      if (ix) acc++;
    end
    chk("fill_count",    32'(acc),         32'(MAXOCC));
    chk("full_in_ready", 32'(up_if.ready), 32'd0);
    chk("full_occ",      32'(occupancy),   32'(MAXOCC));
    @(negedge clk);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    for (int c = 0; c < 20 && mq.size() > 0; c++) tick(ix, ox);
    chk("drain_occ",   32'(occupancy),   32'd0);
    chk("drain_valid", 32'(dn_if.valid), 32'd0);

    // flush with two items held and a coincident input
    dn_if.ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      up_if.valid = 1'b1;
      up_if.data  = DW'(16'h10 + c);
      tick(ix, ox);
    end
    chk("pre_clr_occ", 32'(occupancy), 32'd2);
    clr = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 16'hAAAA;
    #1;
    chk("clr_in_ready", 32'(up_if.ready), 32'd0);
    tick(ix, ox);
    clr = 1'b0;
    up_if.valid = 1'b0;
    #1;
    chk("clr_occ",       32'(occupancy),  32'd0);
    chk("clr_out_valid", 32'(dn_if.valid), 32'd0);
    chk("clr_out_data",  32'(dn_if.data),  32'd0);
    @(negedge clk);

    // random traffic with occasional flush
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      up_if.valid = 1'($urandom_range(0, 1));
      up_if.data  = DW'($urandom);
      dn_if.ready = 1'($urandom_range(0, 1));
      clr         = ($urandom_range(0, 63) == 0);
`ifdef ELASTIC_PIPE_SKID_EN
      #1;
      dn_if.ready = 1'b0; #1; r1 = up_if.ready;
      dn_if.ready = 1'b1; #1; r2 = up_if.ready;
      dn_if.ready = 1'($urandom_range(0, 1));
      if (c % 8 == 0) chk("skid_ready_indep", 32'(r2), 32'(r1));
`endif
      tick(ix, ox);
      if (ix) acc++;
      chk("rand_occ", 32'(occupancy), 32'(mq.size()));
    end
    chk("rand_budget", 32'(acc), 32'd1000);
    clr = 1'b0;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    for (int c = 0; c < 50 && mq.size() > 0; c++) tick(ix, ox);
    chk("rand_drain_occ", 32'(occupancy), 32'd0);

    // asynchronous reset between edges with three items held
    dn_if.ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      up_if.valid = 1'b1;
      up_if.data  = DW'(16'h100 + c);
      tick(ix, ox);
    end
    up_if.valid = 1'b0;
    chk("pre_arst_occ", 32'(occupancy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(dn_if.valid), 32'd0);
    chk("arst_out_data",  32'(dn_if.data),  32'd0);
    chk("arst_occ",       32'(occupancy),   32'd0);
    chk("arst_in_ready",  32'(up_if.ready), 32'd1);
    mq.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);

    dn_if.ready = 1'b1;
    acc = 0; outs = 0;
    for (int c = 0; c < 20 && outs < 4; c++) begin
      up_if.valid = (acc < 4);
      up_if.data  = DW'(16'h200 + acc);
      tick(ix, ox);
      if (c == 0) chk("post_arst_accept", 32'(ix), 32'd1);
      if (ix) acc++;
      if (ox) outs++;
    end
    up_if.valid = 1'b0;
    chk("post_arst_count", 32'(outs), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
